// File: rtl/bullet_controller.sv
// Player-bullet pool: spawns bullets at the ship nose on fire, moves them up every tick,
// retires them at the screen top. Define AUTOFIRE_EN to re-arm fire while the button is held.
module bullet_controller #(
    parameter int BULLET_COUNT   = 8,
    parameter int TICK_PERIOD    = 131072,
    parameter int BULLET_SPEED   = 4,
    parameter int COOLDOWN_TICKS = 6,
    parameter int SHIP_W         = 32,
    parameter int BULLET_W       = 4,
    parameter int BULLET_H       = 8
) (
    input  logic                       clk25,
    input  logic                       rst,
    input  logic                       fire,
    input  logic [9:0]                 ship_x,
    input  logic [9:0]                 ship_y,
    output logic [BULLET_COUNT*10-1:0] bullet_x_flat,
    output logic [BULLET_COUNT*10-1:0] bullet_y_flat,
    output logic [BULLET_COUNT-1:0]    bullet_active_flat,
    output logic                       bullet_fired,
    output logic                       fire_dropped
);

    localparam int TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int CD_W   = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(COOLDOWN_TICKS);
    localparam logic [9:0]        X_OFF     = 10'(SHIP_W / 2 - BULLET_W / 2);
    localparam logic [9:0]        Y_OFF     = 10'(BULLET_H);
    localparam logic [9:0]        SPEED     = 10'(BULLET_SPEED);

    logic fire_s1_q, fire_s1_d;
    logic fire_s2_q, fire_s2_d;
    logic fire_prev_q, fire_prev_d;
    logic pending_q, pending_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic [9:0] bullet_x_q [BULLET_COUNT];
    logic [9:0] bullet_x_d [BULLET_COUNT];
    logic [9:0] bullet_y_q [BULLET_COUNT];
    logic [9:0] bullet_y_d [BULLET_COUNT];
    logic [BULLET_COUNT-1:0] active_q, active_d;
    logic fired_q, fired_d;
    logic dropped_q, dropped_d;

    logic tick;
    logic fire_req;
    logic service;
    logic slot_found;
    logic [BULLET_COUNT-1:0] spawn_sel;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;

    always_comb begin
        fire_s1_d   = fire;
        fire_s2_d   = fire_s1_q;
        fire_prev_d = fire_s2_q;
`ifdef AUTOFIRE_EN
        fire_req = fire_s2_q;
`else
        fire_req = fire_s2_q & ~fire_prev_q;
`endif

        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

        // Lowest free slot, judged on last cycle's state so a slot retiring now stays busy
        slot_found = 1'b0;
        spawn_sel  = '0;
        for (int i = 0; i < BULLET_COUNT; i++) begin
            if (!active_q[i] && !slot_found) begin
                spawn_sel[i] = 1'b1;
                slot_found   = 1'b1;
            end
        end

        service   = pending_q && (cooldown_q == '0);
        fired_d   = service && slot_found;
        dropped_d = service && !slot_found;
        pending_d = pending_q ? ~service : fire_req;

        spawn_x = ship_x + X_OFF;
        spawn_y = (ship_y >= Y_OFF) ? ship_y - Y_OFF : '0;

        bullet_x_d = bullet_x_q;
        bullet_y_d = bullet_y_q;
        active_d   = active_q;
        for (int i = 0; i < BULLET_COUNT; i++) begin
            if (fired_d && spawn_sel[i]) begin
                active_d[i]   = 1'b1;
                bullet_x_d[i] = spawn_x;
                bullet_y_d[i] = spawn_y;
            end else if (tick && active_q[i]) begin
                if (bullet_y_q[i] >= SPEED) begin
                    bullet_y_d[i] = bullet_y_q[i] - SPEED;
                end else begin
                    active_d[i] = 1'b0;
                end
            end
        end

        cooldown_d = cooldown_q;
        if (fired_d) begin
            cooldown_d = CD_LOAD;
        end else if (tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            fire_s1_q   <= 1'b0;
            fire_s2_q   <= 1'b0;
            fire_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            tick_cnt_q  <= '0;
            cooldown_q  <= '0;
            bullet_x_q  <= '{default: '0};
            bullet_y_q  <= '{default: '0};
            active_q    <= '0;
            fired_q     <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            fire_s1_q   <= fire_s1_d;
            fire_s2_q   <= fire_s2_d;
            fire_prev_q <= fire_prev_d;
            pending_q   <= pending_d;
            tick_cnt_q  <= tick_cnt_d;
            cooldown_q  <= cooldown_d;
            bullet_x_q  <= bullet_x_d;
            bullet_y_q  <= bullet_y_d;
            active_q    <= active_d;
            fired_q     <= fired_d;
            dropped_q   <= dropped_d;
        end
    end

    for (genvar g = 0; g < BULLET_COUNT; g++) begin : g_pack
        assign bullet_x_flat[g*10 +: 10] = bullet_x_q[g];
        assign bullet_y_flat[g*10 +: 10] = bullet_y_q[g];
    end

    assign bullet_active_flat = active_q;
    assign bullet_fired       = fired_q;
    assign fire_dropped       = dropped_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Randomized bench for bullet_controller: a behavioural pool model predicts spawn/drop
// events into a scoreboard queue that a negedge monitor pops whenever the DUT pulses.
module tb_bullet_controller;

    localparam int TP    = 16;
    localparam int CD    = 6;
    localparam int N     = 8;
    localparam int SPEED = 4;

    logic clk25 = 1'b0;
    logic rst;
    logic fire;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic [N*10-1:0] bullet_x_flat;
    logic [N*10-1:0] bullet_y_flat;
    logic [N-1:0] bullet_active_flat;
    logic bullet_fired;
    logic fire_dropped;

    always #5 clk25 = ~clk25;

    bullet_controller #(
        .BULLET_COUNT(N),
        .TICK_PERIOD(TP),
        .BULLET_SPEED(SPEED),
        .COOLDOWN_TICKS(CD)
    ) dut (
        .clk25(clk25),
        .rst(rst),
        .fire(fire),
        .ship_x(ship_x),
        .ship_y(ship_y),
        .bullet_x_flat(bullet_x_flat),
        .bullet_y_flat(bullet_y_flat),
        .bullet_active_flat(bullet_active_flat),
        .bullet_fired(bullet_fired),
        .fire_dropped(fire_dropped)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit drop;
        int slot;
        int x;
        int y;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    // Reference pool state
    int m_x[N];
    int m_y[N];
    bit m_act[N];
    int m_cnt;
    int m_cd;
    bit m_pend;
    bit fire_hist[$];
    int cyc = 0;

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
            m_act[i] = 1'b0;
        end
        m_cnt = 0;
        m_cd = 0;
        m_pend = 1'b0;
        fire_hist = '{1'b0, 1'b0, 1'b0};
        exp_q.delete();
    endfunction

    // One clock of the pool rules; fire reaches the request logic after two sync stages
    function automatic void modelStep();
        bit rise;
        bit tick;
        bit serve;
        int free_slot;
        ev_t ev;
        cyc++;
        rise = fire_hist[1] && !fire_hist[0];
        void'(fire_hist.pop_front());
        fire_hist.push_back(fire);
        tick = (m_cnt == TP - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        serve = m_pend && (m_cd == 0);
        free_slot = -1;
        for (int i = 0; i < N; i++) begin
            if (!m_act[i] && free_slot < 0) free_slot = i;
        end
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    if (m_y[i] >= SPEED) m_y[i] = m_y[i] - SPEED;
                    else m_act[i] = 1'b0;
                end
            end
        end
        if (serve && free_slot >= 0) begin
            m_act[free_slot] = 1'b1;
            m_x[free_slot] = (int'(ship_x) + 14) % 1024;
            m_y[free_slot] = (ship_y >= 8) ? int'(ship_y) - 8 : 0;
            m_cd = CD;
            ev.drop = 1'b0;
            ev.slot = free_slot;
            ev.x = m_x[free_slot];
            ev.y = m_y[free_slot];
            ev.cyc = cyc;
            exp_q.push_back(ev);
        end else begin
            if (serve) begin
                ev.drop = 1'b1;
                ev.slot = 0;
                ev.x = 0;
                ev.y = 0;
                ev.cyc = cyc;
                exp_q.push_back(ev);
            end
            if (tick && m_cd > 0) m_cd = m_cd - 1;
        end
        m_pend = m_pend ? !serve : rise;
    endfunction

    initial begin
        forever begin
            @(posedge clk25 or posedge rst);
            if (rst) modelReset();
            else modelStep();
        end
    end

    // Monitor: every DUT pulse must match the next predicted event, at the predicted cycle
    always @(negedge clk25) begin
        ev_t ev;
        if (!rst && (bullet_fired === 1'b1 || fire_dropped === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {78'd0, bullet_fired, fire_dropped}, 80'd0);
            end else begin
                ev = exp_q.pop_front();
                checkOutput("pulse_kind", {78'd0, bullet_fired, fire_dropped}, ev.drop ? 80'd1 : 80'd2);
                checkOutput("pulse_time", 80'(cyc), 80'(ev.cyc));
                if (!ev.drop) begin
                    checkOutput("spawn_x", 80'(bullet_x_flat[ev.slot*10 +: 10]), 80'(ev.x));
                    checkOutput("spawn_y", 80'(bullet_y_flat[ev.slot*10 +: 10]), 80'(ev.y));
                    checkOutput("spawn_active", 80'(bullet_active_flat[ev.slot]), 80'd1);
                end
            end
        end
    end

    task automatic compareState(input string label);
        logic [N*10-1:0] ex;
        logic [N*10-1:0] ey;
        logic [N-1:0] ea;
        for (int i = 0; i < N; i++) begin
            ex[i*10 +: 10] = 10'(m_x[i]);
            ey[i*10 +: 10] = 10'(m_y[i]);
            ea[i] = m_act[i];
        end
        checkOutput({label, "_x"}, 80'(bullet_x_flat), 80'(ex));
        checkOutput({label, "_y"}, 80'(bullet_y_flat), 80'(ey));
        checkOutput({label, "_active"}, 80'(bullet_active_flat), 80'(ea));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk25);
        #2;
    endtask

    task automatic applyStimulus(input int x, input int y, input int width, input int gap);
        step(1);
        ship_x = 10'(x);
        ship_y = 10'(y);
        fire = 1'b1;
        step(width);
        fire = 1'b0;
        step(gap);
    endtask

    task automatic doReset();
        step(3);
        checkOutput("queue_drained", 80'(exp_q.size()), 80'd0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        @(negedge clk25);
        compareState("after_reset");
    endtask

    task automatic waitPulse(input bit want_drop, input int budget, output int lat);
        lat = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk25);
            if ((want_drop ? fire_dropped : bullet_fired) === 1'b1) begin
                lat = c + 1;
                break;
            end
        end
        checkOutput(want_drop ? "drop_seen" : "fire_seen", 80'(lat > 0), 80'd1);
    endtask

    initial begin
        int lat;
        int y0;
        rst = 1'b1;
        fire = 1'b0;
        ship_x = '0;
        ship_y = '0;
        step(3);
        rst = 1'b0;
        @(negedge clk25);
        compareState("reset");
        checkOutput("reset_pulses", {78'd0, bullet_fired, fire_dropped}, 80'd0);

        // Single shot at (100,400)
        step(1);
        ship_x = 10'd100;
        ship_y = 10'd400;
        fire = 1'b1;
        waitPulse(1'b0, 10, lat);
        checkOutput("fire_latency_ok", 80'(lat >= 2 && lat <= 5), 80'd1);
        checkOutput("shot_x", 80'(bullet_x_flat[9:0]), 80'd114);
        checkOutput("shot_y", 80'(bullet_y_flat[9:0]), 80'd392);
        @(negedge clk25);
        checkOutput("fired_one_cycle", 80'(bullet_fired), 80'd0);
        for (int c = 0; c < 2 * TP; c++) begin
            @(negedge clk25);
            if (bullet_y_flat[9:0] != 10'd392) break;
        end
        checkOutput("shot_after_tick", 80'(bullet_y_flat[9:0]), 80'd388);

        // Second press during cooldown waits, then lands in slot 1
        step(10);
        fire = 1'b0;
        step(2);
        applyStimulus(200, 300, 2, 0);
        waitPulse(1'b0, (CD + 1) * TP + 10, lat);
        checkOutput("cooldown_slot1", 80'(bullet_active_flat[1:0]), 80'd3);
        checkOutput("cooldown_x1", 80'(bullet_x_flat[19:10]), 80'd214);
        checkOutput("held_fire_single", 80'(bullet_active_flat), 80'd3);

        // Mid-flight reset with three bullets active
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(50 + k * 20, 600, 2, (CD + 1) * TP);
        @(negedge clk25);
        checkOutput("three_active", 80'(bullet_active_flat), 80'h7);
        step(1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_active", 80'(bullet_active_flat), 80'd0);
        checkOutput("async_rst_x", 80'(bullet_x_flat), 80'd0);
        checkOutput("async_rst_y", 80'(bullet_y_flat), 80'd0);
        step(2);
        rst = 1'b0;

        // Fill the pool, then one more press is dropped
        doReset();
        for (int k = 0; k < N; k++) applyStimulus($urandom_range(0, 1023), 900, 2, (CD + 1) * TP);
        @(negedge clk25);
        checkOutput("pool_full", 80'(bullet_active_flat), 80'hFF);
        applyStimulus(10, 900, 2, 0);
        waitPulse(1'b1, 20, lat);
        @(negedge clk25);
        checkOutput("drop_one_cycle", 80'(fire_dropped), 80'd0);
        compareState("after_drop");

        // Low ship: spawn clamps to y=0 and retires on the next tick
        doReset();
        applyStimulus(300, 5, 2, 0);
        waitPulse(1'b0, 10, lat);
        checkOutput("low_spawn_y", 80'(bullet_y_flat[9:0]), 80'd0);
        for (int c = 0; c < 2 * TP; c++) begin
            @(negedge clk25);
            if (!bullet_active_flat[0]) break;
        end
        checkOutput("low_retired", 80'(bullet_active_flat[0]), 80'd0);

        // Time the press so the spawn lands on a tick cycle
        step((CD + 1) * TP);
        for (int c = 0; c < 2 * TP; c++) begin
            step(1);
            if (m_cnt == TP - 4) break;
        end
        ship_x = 10'd500;
        ship_y = 10'd300;
        fire = 1'b1;
        waitPulse(1'b0, 10, lat);
        y0 = int'(bullet_y_flat[9:0]);
        checkOutput("tick_spawn_unmoved", 80'(y0), 80'd292);
        fire = 1'b0;

        // Random presses, ship positions and gaps
        doReset();
        for (int k = 0; k < 40; k++) begin
            applyStimulus($urandom_range(0, 1023),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 1023),
                          $urandom_range(1, 4), $urandom_range(3, 150));
            @(negedge clk25);
            compareState("random");
        end

        step(10);
        checkOutput("final_queue_empty", 80'(exp_q.size()), 80'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
